// File: rtl/down_count_checker.sv
// Monitors a free-running down-counter: locks after two clean decrements,
// counts wraps while locked, and tracks mismatches with a sticky flag and counter.
module down_count_checker #(
  parameter int WIDTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clear_err,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              locked,
  output logic              err_flag,
  output logic [7:0]        err_count
);
  localparam int MW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [1:0]       run;
  logic [MW-1:0]    miss;

  logic [WIDTH-1:0] prev_m1;
  logic             dec, hold, wrap;
  logic [1:0]       run_nx;
  logic [MW-1:0]    miss_nx;
  logic [7:0]       err_base;

  always_comb begin
    prev_m1  = prev - WIDTH'(1);
    dec      = (cnt_in == prev_m1);
    hold     = (cnt_in == prev);
    wrap     = dec && (prev == '0);
    run_nx   = run + 2'd1;
    miss_nx  = miss + MW'(1);
    // Clear takes effect first so a same-edge mismatch still lands on top of it.
    err_base = clear_err ? 8'd0 : err_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      miss       <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      locked     <= 1'b0;
      err_flag   <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clear_err) begin
        err_flag  <= 1'b0;
        err_count <= 8'd0;
      end
      if (cnt_valid) begin
        prev <= cnt_in;
        case (state)
          IDLE: begin
            state <= SYNC;
            run   <= '0;
          end
          SYNC: begin
            if (dec) begin
              if (run_nx == 2'd2) begin
                state  <= TRACK;
                locked <= 1'b1;
                run    <= '0;
                miss   <= '0;
              end else begin
                run <= run_nx;
              end
            end else if (!hold) begin
              run <= '0;
            end
          end
          TRACK: begin
            if (dec) begin
              miss <= '0;
              if (wrap) begin
                wrap_pulse <= 1'b1;
                wrap_count <= wrap_count + WRAP_W'(1);
              end
            end else if (!hold) begin
              err_flag  <= 1'b1;
              err_count <= (err_base == 8'hFF) ? 8'hFF : err_base + 8'd1;
              if (miss_nx == MW'(ERR_LIMIT)) begin
                state  <= SYNC;
                locked <= 1'b0;
                run    <= '0;
                miss   <= '0;
              end else begin
                miss <= miss_nx;
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_down_count_checker.sv
// Directed-vector bench for down_count_checker (default parameters).
module tb_down_count_checker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       cnt_valid = 1'b0;
  logic       clear_err = 1'b0;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       locked;
  logic       err_flag;
  logic [7:0] err_count;

  int compared = 0;
  int mismatched = 0;

  down_count_checker dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .clear_err(clear_err), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .locked(locked), .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Drive one sample, clock it in, and settle 1 time unit past the edge.
  task automatic step(input logic [3:0] v, input logic vld = 1'b1);
    cnt_in = v;
    cnt_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL reset_locked got %0b want 0", locked); end
    compared++; if (wrap_count !== 8'd0) begin mismatched++; $display("FAIL reset_wrap_count got %0d want 0", wrap_count); end
    compared++; if (err_count !== 8'd0 || err_flag !== 1'b0 || wrap_pulse !== 1'b0)
      begin mismatched++; $display("FAIL reset_err got cnt=%0d flag=%0b pulse=%0b want 0/0/0", err_count, err_flag, wrap_pulse); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock();
    step(4'd5);
    compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL lock_edge1 got %0b want 0", locked); end
    step(4'd4);
    compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL lock_edge2 got %0b want 0", locked); end
    step(4'd3);
    compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL lock_edge3 got %0b want 1", locked); end
    compared++; if (err_count !== 8'd0) begin mismatched++; $display("FAIL lock_errs got %0d want 0", err_count); end
  endtask

  task automatic test_wrap();
    step(4'd2); step(4'd1); step(4'd0);
    compared++; if (wrap_pulse !== 1'b0 || wrap_count !== 8'd0)
      begin mismatched++; $display("FAIL wrap_pre got pulse=%0b cnt=%0d want 0/0", wrap_pulse, wrap_count); end
    step(4'd15);
    compared++; if (wrap_pulse !== 1'b1) begin mismatched++; $display("FAIL wrap_pulse got %0b want 1", wrap_pulse); end
    compared++; if (wrap_count !== 8'd1) begin mismatched++; $display("FAIL wrap_count got %0d want 1", wrap_count); end
    step(4'd14);
    compared++; if (wrap_pulse !== 1'b0 || wrap_count !== 8'd1)
      begin mismatched++; $display("FAIL wrap_post got pulse=%0b cnt=%0d want 0/1", wrap_pulse, wrap_count); end
  endtask

  task automatic test_valid_gate();
    // prev is 14; a bogus value with valid low must be ignored
    for (int i = 0; i < 3; i++) step(4'd3, 1'b0);
    compared++; if (err_flag !== 1'b0 || wrap_pulse !== 1'b0)
      begin mismatched++; $display("FAIL gate_hold got flag=%0b pulse=%0b want 0/0", err_flag, wrap_pulse); end
    step(4'd13);
    compared++; if (err_flag !== 1'b0 || locked !== 1'b1)
      begin mismatched++; $display("FAIL gate_resume got flag=%0b locked=%0b want 0/1", err_flag, locked); end
  endtask

  task automatic test_single_miss();
    step(4'd12); step(4'd11); step(4'd10); step(4'd9);
    step(4'd6);
    compared++; if (err_flag !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1)
      begin mismatched++; $display("FAIL miss_one got flag=%0b cnt=%0d locked=%0b want 1/1/1", err_flag, err_count, locked); end
    step(4'd5);
    // two more misses must not unlock: the DEC above cleared the miss run
    step(4'd1); step(4'd8);
    compared++; if (err_count !== 8'd3 || locked !== 1'b1)
      begin mismatched++; $display("FAIL miss_cleared got cnt=%0d locked=%0b want 3/1", err_count, locked); end
    step(4'd7);
    compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL miss_dec got locked=%0b want 1", locked); end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    step(4'd13); step(4'd12); step(4'd11);
    compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL loss_prelock got %0b want 1", locked); end
    // from 11 every one of 9,2,13 is a mismatch
    step(4'd9); step(4'd2);
    compared++; if (locked !== 1'b1 || err_count !== 8'd2)
      begin mismatched++; $display("FAIL loss_two got locked=%0b cnt=%0d want 1/2", locked, err_count); end
    step(4'd13);
    compared++; if (locked !== 1'b0 || err_count !== 8'd3)
      begin mismatched++; $display("FAIL loss_three got locked=%0b cnt=%0d want 0/3", locked, err_count); end
    step(4'd12);
    compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL relock_one got %0b want 0", locked); end
    step(4'd11);
    compared++; if (locked !== 1'b1 || err_count !== 8'd3)
      begin mismatched++; $display("FAIL relock_two got locked=%0b cnt=%0d want 1/3", locked, err_count); end
  endtask

  task automatic test_clear_with_miss();
    step(4'd5); step(4'd4);
    compared++; if (err_count !== 8'd4 || locked !== 1'b1)
      begin mismatched++; $display("FAIL clr_setup got cnt=%0d locked=%0b want 4/1", err_count, locked); end
    clear_err = 1'b1;
    step(4'd9);
    compared++; if (err_count !== 8'd1 || err_flag !== 1'b1)
      begin mismatched++; $display("FAIL clr_same_edge got cnt=%0d flag=%0b want 1/1", err_count, err_flag); end
    step(4'd8);
    clear_err = 1'b0;
    compared++; if (err_count !== 8'd0 || err_flag !== 1'b0)
      begin mismatched++; $display("FAIL clr_plain got cnt=%0d flag=%0b want 0/0", err_count, err_flag); end
  endtask

  task automatic test_reset_mid_track();
    step(4'd7); step(4'd6); step(4'd5); step(4'd4); step(4'd3); step(4'd2); step(4'd1); step(4'd0); step(4'd15);
    compared++; if (locked !== 1'b1 || wrap_count !== 8'd1)
      begin mismatched++; $display("FAIL mid_setup got locked=%0b wraps=%0d want 1/1", locked, wrap_count); end
    #2 reset = 1'b1;
    #1;
    compared++; if (locked !== 1'b0 || wrap_count !== 8'd0 || wrap_pulse !== 1'b0 || err_flag !== 1'b0 || err_count !== 8'd0)
      begin mismatched++; $display("FAIL mid_async got locked=%0b wraps=%0d pulse=%0b flag=%0b cnt=%0d want all 0",
                                   locked, wrap_count, wrap_pulse, err_flag, err_count); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(4'd0);
    compared++; if (locked !== 1'b0 || err_flag !== 1'b0 || err_count !== 8'd0)
      begin mismatched++; $display("FAIL mid_hold got locked=%0b flag=%0b cnt=%0d want 0/0/0", locked, err_flag, err_count); end
    // a wrap seen while still in SYNC neither pulses nor counts
    step(4'd15);
    compared++; if (wrap_pulse !== 1'b0 || wrap_count !== 8'd0 || locked !== 1'b0)
      begin mismatched++; $display("FAIL sync_wrap got pulse=%0b wraps=%0d locked=%0b want 0/0/0", wrap_pulse, wrap_count, locked); end
    step(4'd14);
    compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL mid_relock got %0b want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_valid_gate();
    test_single_miss();
    test_loss_of_lock();
    test_clear_with_miss();
    test_reset_mid_track();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
